// File: rtl/pipe_seq_ctrl.sv
// Sequencing and hazard controller for a 5-stage pipeline: run/step/drain/halt
// FSM, load-use bubble insertion, and saturating cycle/stall counters.
module pipe_seq_ctrl #(
   parameter int REG_ADDR_WIDTH = 3,
   parameter int DRAIN_CYCLES   = 4,
   parameter int CNT_WIDTH      = 32
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      run,
   input  logic                      step,
   input  logic [REG_ADDR_WIDTH-1:0] id_rs1,
   input  logic [REG_ADDR_WIDTH-1:0] id_rs2,
   input  logic                      id_rs1_used,
   input  logic                      id_rs2_used,
   input  logic                      id_halt,
   input  logic                      ex_mem_read,
   input  logic [REG_ADDR_WIDTH-1:0] ex_w_reg,
   output logic                      pc_en,
   output logic                      if_id_en,
   output logic                      pipe_en,
   output logic                      id_ex_bubble,
   output logic [2:0]                state_o,
   output logic                      halted,
   output logic [CNT_WIDTH-1:0]      cycle_cnt,
   output logic [CNT_WIDTH-1:0]      stall_cnt
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_RUN    = 3'd1,
      S_STEP   = 3'd2,
      S_DRAIN  = 3'd3,
      S_HALTED = 3'd4
   } state_e;

   localparam logic [7:0] DRAIN_INIT = 8'(DRAIN_CYCLES - 1);

   state_e               state_q, state_d;
   logic [7:0]           drain_q, drain_d;
   logic                 halt_seen_q, halt_seen_d;
   logic [CNT_WIDTH-1:0] cycle_q, cycle_d;
   logic [CNT_WIDTH-1:0] stall_q, stall_d;
   logic                 hazard;
   logic                 stall_inc;

   assign hazard = ex_mem_read &
                   ((id_rs1_used & (id_rs1 == ex_w_reg)) |
                    (id_rs2_used & (id_rs2 == ex_w_reg)));

   always_comb begin
      state_d      = state_q;
      drain_d      = drain_q;
      halt_seen_d  = halt_seen_q;
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      pipe_en      = 1'b0;
      id_ex_bubble = 1'b0;
      stall_inc    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (run)       state_d = S_RUN;
            else if (step) state_d = S_STEP;
         end
         S_RUN: begin
            pipe_en = 1'b1;
            if (!run) begin
               id_ex_bubble = 1'b1;
               stall_inc    = hazard;
               halt_seen_d  = id_halt;
               drain_d      = DRAIN_INIT;
               state_d      = S_DRAIN;
            end else if (hazard) begin
               id_ex_bubble = 1'b1;
               stall_inc    = 1'b1;
            end else if (id_halt) begin
               id_ex_bubble = 1'b1;
               halt_seen_d  = 1'b1;
               drain_d      = DRAIN_INIT;
               state_d      = S_DRAIN;
            end else begin
               pc_en    = 1'b1;
               if_id_en = 1'b1;
            end
         end
         S_STEP: begin
            // single advance: a hazard bubble or a taken halt consumes the step
            pipe_en = 1'b1;
            state_d = S_IDLE;
            if (hazard) begin
               id_ex_bubble = 1'b1;
               stall_inc    = 1'b1;
            end else if (id_halt) begin
               id_ex_bubble = 1'b1;
               halt_seen_d  = 1'b1;
               drain_d      = DRAIN_INIT;
               state_d      = S_DRAIN;
            end else begin
               pc_en    = 1'b1;
               if_id_en = 1'b1;
            end
         end
         S_DRAIN: begin
            pipe_en      = 1'b1;
            id_ex_bubble = 1'b1;
            if (drain_q == 8'd0) begin
               state_d     = halt_seen_q ? S_HALTED : S_IDLE;
               halt_seen_d = 1'b0;
            end else begin
               drain_d = drain_q - 8'd1;
            end
         end
         S_HALTED: ;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      cycle_d = cycle_q;
      stall_d = stall_q;
      if (pipe_en && (cycle_q != '1))   cycle_d = cycle_q + 1'b1;
      if (stall_inc && (stall_q != '1)) stall_d = stall_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         drain_q     <= 8'd0;
         halt_seen_q <= 1'b0;
         cycle_q     <= '0;
         stall_q     <= '0;
      end else begin
         state_q     <= state_d;
         drain_q     <= drain_d;
         halt_seen_q <= halt_seen_d;
         cycle_q     <= cycle_d;
         stall_q     <= stall_d;
      end
   end

   assign state_o   = state_q;
   assign halted    = (state_q == S_HALTED);
   assign cycle_cnt = cycle_q;
   assign stall_cnt = stall_q;

endmodule

// File: tb/tb_pipe_seq_ctrl.sv
// Scoreboard bench for pipe_seq_ctrl: directed and random stimulus, expected
// per-cycle outputs from a behavioural model, checked by a separate monitor.
module tb_pipe_seq_ctrl;

   localparam int DC = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset, run, step, id_rs1_used, id_rs2_used, id_halt, ex_mem_read;
   logic [2:0] id_rs1, id_rs2, ex_w_reg;
   logic       pc_en, if_id_en, pipe_en, id_ex_bubble, halted;
   logic [2:0] state_o;
   logic [31:0] cycle_cnt, stall_cnt;
   logic       pc_en4, if_id_en4, pipe_en4, id_ex_bubble4, halted4;
   logic [2:0] state_o4;
   logic [3:0] cycle_cnt4, stall_cnt4;

   pipe_seq_ctrl #(.REG_ADDR_WIDTH(3), .DRAIN_CYCLES(DC), .CNT_WIDTH(32)) dut (
      .clk(clk), .reset(reset), .run(run), .step(step),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
      .id_halt(id_halt), .ex_mem_read(ex_mem_read), .ex_w_reg(ex_w_reg),
      .pc_en(pc_en), .if_id_en(if_id_en), .pipe_en(pipe_en), .id_ex_bubble(id_ex_bubble),
      .state_o(state_o), .halted(halted), .cycle_cnt(cycle_cnt), .stall_cnt(stall_cnt));

   pipe_seq_ctrl #(.REG_ADDR_WIDTH(3), .DRAIN_CYCLES(DC), .CNT_WIDTH(4)) dut4 (
      .clk(clk), .reset(reset), .run(run), .step(step),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
      .id_halt(id_halt), .ex_mem_read(ex_mem_read), .ex_w_reg(ex_w_reg),
      .pc_en(pc_en4), .if_id_en(if_id_en4), .pipe_en(pipe_en4), .id_ex_bubble(id_ex_bubble4),
      .state_o(state_o4), .halted(halted4), .cycle_cnt(cycle_cnt4), .stall_cnt(stall_cnt4));

   typedef struct {
      logic       pc, ifid, pipe, bub, hlt;
      logic [2:0] st;
      longint     cyc, stl;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   failures = 0;

   // behavioural model: 0 idle, 1 run, 2 step, 3 drain, 4 halted
   int     m_st = 0;
   int     m_left = 0;
   bit     m_hs = 0;
   longint m_cyc = 0, m_stl = 0;

   task automatic model_cycle(output exp_t e);
      bit hz, active, decodes, fetch;
      hz = ex_mem_read && ((id_rs1_used && id_rs1 == ex_w_reg) ||
                           (id_rs2_used && id_rs2 == ex_w_reg));
      active  = (m_st >= 1 && m_st <= 3);
      decodes = (m_st == 1 && run) || m_st == 2;
      fetch   = decodes && !hz && !id_halt;
      e.pc = fetch; e.ifid = fetch; e.pipe = active; e.bub = active && !fetch;
      e.st = 3'(m_st); e.hlt = (m_st == 4); e.cyc = m_cyc; e.stl = m_stl;
      if (reset) begin
         m_st = 0; m_left = 0; m_hs = 0; m_cyc = 0; m_stl = 0;
         return;
      end
      if (active) m_cyc++;
      if ((m_st == 1 || m_st == 2) && hz) m_stl++;
      case (m_st)
         0: m_st = run ? 1 : (step ? 2 : 0);
         1: if (!run) begin m_hs = id_halt; m_left = DC; m_st = 3; end
            else if (!hz && id_halt) begin m_hs = 1; m_left = DC; m_st = 3; end
         2: if (!hz && id_halt) begin m_hs = 1; m_left = DC; m_st = 3; end
            else m_st = 0;
         3: begin
               m_left--;
               if (m_left == 0) begin m_st = m_hs ? 4 : 0; m_hs = 0; end
            end
         default: ;
      endcase
   endtask

   task automatic tick(input bit rst, ru, st, hl, mr, u1, u2,
                       input bit [2:0] r1, r2, wr, input bit push = 1);
      exp_t e;
      @(posedge clk); #1;
      reset = rst; run = ru; step = st; id_halt = hl; ex_mem_read = mr;
      id_rs1_used = u1; id_rs2_used = u2; id_rs1 = r1; id_rs2 = r2; ex_w_reg = wr;
      if (push) begin
         model_cycle(e);
         q.push_back(e);
      end
   endtask

   task automatic t(input bit rst, ru, st);
      tick(rst, ru, st, 0, 0, 0, 0, 3'd0, 3'd0, 3'd0);
   endtask

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d (time %0t)", nm, act, exp, $time);
      end
   endtask

   // monitor: outputs are presented every cycle, sampled mid-cycle
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (q.size() > 0) begin
            e = q.pop_front();
            chk("pc_en",        {63'd0, pc_en},        {63'd0, e.pc});
            chk("if_id_en",     {63'd0, if_id_en},     {63'd0, e.ifid});
            chk("pipe_en",      {63'd0, pipe_en},      {63'd0, e.pipe});
            chk("id_ex_bubble", {63'd0, id_ex_bubble}, {63'd0, e.bub});
            chk("state_o",      {61'd0, state_o},      {61'd0, e.st});
            chk("halted",       {63'd0, halted},       {63'd0, e.hlt});
            chk("cycle_cnt",    {32'd0, cycle_cnt},    64'(e.cyc));
            chk("stall_cnt",    {32'd0, stall_cnt},    64'(e.stl));
            chk("cycle_cnt_w4", {60'd0, cycle_cnt4},   64'(e.cyc > 15 ? 15 : e.cyc));
            chk("stall_cnt_w4", {60'd0, stall_cnt4},   64'(e.stl > 15 ? 15 : e.stl));
         end
      end
   end

   initial begin
      bit rst_r;
      // two unchecked reset cycles bring the DUT out of X, then model starts in sync
      tick(1, 0, 0, 0, 0, 0, 0, 3'd0, 3'd0, 3'd0, 0);
      tick(1, 0, 0, 0, 0, 0, 0, 3'd0, 3'd0, 3'd0, 0);
      t(1, 0, 0);
      repeat (10) t(0, 0, 0);
      repeat (21) t(0, 1, 0);
      // load-use on rs2, then same match with rs2 unused
      tick(0, 1, 0, 0, 1, 1, 1, 3'd0, 3'd3, 3'd3);
      tick(0, 1, 0, 0, 1, 1, 0, 3'd0, 3'd3, 3'd3);
      // hazard wins over halt, then halt taken
      tick(0, 1, 0, 1, 1, 1, 0, 3'd3, 3'd0, 3'd3);
      tick(0, 1, 0, 1, 0, 0, 0, 3'd0, 3'd0, 3'd0);
      repeat (DC + 1) t(0, 1, 0);
      repeat (4) t(0, 1, 1);
      // single step, then step with run
      t(1, 0, 0);
      t(0, 0, 1);
      repeat (3) t(0, 0, 0);
      t(0, 1, 1);
      repeat (3) t(0, 1, 0);
      // drop run, reset during the 2nd drain cycle
      t(0, 0, 0);
      t(0, 0, 0);
      t(1, 0, 0);
      repeat (3) t(0, 0, 0);
      // halt taken during a step
      t(0, 0, 1);
      tick(0, 0, 0, 1, 0, 0, 0, 3'd0, 3'd0, 3'd0);
      repeat (DC + 3) t(0, 0, 0);
      t(1, 0, 0);
      // random traffic
      for (int i = 0; i < 3000; i++) begin
         rst_r = ($urandom_range(0, 59) == 0) || (m_st == 4 && $urandom_range(0, 3) == 0);
         tick(rst_r, $urandom_range(0, 7) != 0, $urandom_range(0, 3) == 0,
              $urandom_range(0, 19) == 0, $urandom_range(0, 2) == 0,
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
      end
      repeat (3) @(negedge clk);
      checks++;
      if (q.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
